condicionador_botao: RTL and testbench
======================================

// Module: condicionador_botao
// PURPOSE
//  Conditions the raw pedestrian push-button ahead of the traffic-light FSM: 2-flop synchronizer,
//  debounce filter, rising-edge detect and a sticky request held until the light FSM acknowledges.
//  Output pedido drives the light FSM's botao input; the FSM pulses ack when it services the request.
// PARAMETERS
//  DEB_CYCLES      1000   consecutive stable cycles needed to accept a level change (>=2)
//  DEB_W           10     width of debounce counter (must hold DEB_CYCLES-1)
//  LOCKOUT_CYCLES  20000  post-ack dead time in cycles (only with BOTAO_LOCKOUT_EN)
//  LCK_W           15     width of lockout counter (must hold LOCKOUT_CYCLES-1)
// PORTS
//  clock        in   1  system clock, all state on posedge
//  reset        in   1  asynchronous, active-high; clears all state
//  botao_raw    in   1  raw, asynchronous, bouncing button level (1 = pressed)
//  ack          in   1  one-cycle acknowledge from light FSM (request consumed)
//  pedido       out  1  pending pedestrian request, level, held until ack
//  pressionado  out  1  debounced button level
//  n_pedidos    out  8  count of accepted requests, saturates at 255
// BEHAVIOUR
//  Reset (async, high): sync flops=0, filtrado=0, deb counter=0, state=IDLE, lockout counter=0;
//   pedido=0, pressionado=0, n_pedidos=0. Release takes effect on next posedge.
//  Sync: s1<=botao_raw, s<=s1. Only s is used downstream.
//  Debounce: if s==filtrado -> cnt<=0. Else if cnt==DEB_CYCLES-1 -> filtrado<=s, cnt<=0; else cnt++.
//   Any glitch shorter than DEB_CYCLES cycles (at s) is discarded, counter restarts.
//  Edge: rise = filtrado & ~filtrado_d (filtrado_d registered). Falling edges ignored.
//  Latency: first edge sampling botao_raw=1 is edge 0; filtrado=1 after edge DEB_CYCLES+1;
//   pedido=1 after edge DEB_CYCLES+2 (if in IDLE). pressionado = filtrado.
//  FSM (registered, 2 bits):
//   IDLE     : rise -> PENDENTE, n_pedidos++ (sat 255). ack ignored.
//   PENDENTE : pedido=1. ack -> IDLE (or BLOQUEIO with macro). rise ignored (no stacking, no count).
//   BLOQUEIO : lockout cnt counts 0..LOCKOUT_CYCLES-1 then -> IDLE; rise dropped, not counted.
//   Illegal encoding -> IDLE.
//  Simultaneous ack and rise in PENDENTE: ack wins, rise dropped (button must be re-pressed).
//  Button held continuously: exactly one request; new request needs release+re-press (both debounced).
//  Reset mid-operation with button held: after release filtrado=0, so a held button produces a fresh
//   request DEB_CYCLES+3 edges later.
//  n_pedidos at 255 stays 255; requests still accepted.
// CONFIGURATION
//  BOTAO_LOCKOUT_EN defined: PENDENTE+ack -> BLOQUEIO for LOCKOUT_CYCLES cycles, then IDLE.
//  Not defined: PENDENTE+ack -> IDLE directly; BLOQUEIO state and lockout counter not built,
//   LOCKOUT_CYCLES/LCK_W unused; a rise on the cycle after ack is accepted.
// TESTING (DEB_CYCLES=4, LOCKOUT_CYCLES=8 for the bench)
//  1 Clean press: botao_raw=1 from edge 0 -> pressionado=1 after edge 5, pedido=1 after edge 6,
//    n_pedidos=1; hold 50 cycles -> pedido stays 1, n_pedidos stays 1.
//  2 Bounce: toggle botao_raw 1/0 every 2 cycles for 20 cycles, then 0 -> pressionado, pedido,
//    n_pedidos remain 0 throughout.
//  3 Ack: pedido=1, pulse ack 1 cycle -> pedido=0 next edge; release+re-press (each held 6+ cycles)
//    -> second request, n_pedidos=2 (without macro). With BOTAO_LOCKOUT_EN: re-press whose rise lands
//    within 8 cycles after ack -> no request, n_pedidos=1; re-press after lockout -> n_pedidos=2.
//  4 Collision: in PENDENTE, ack on same cycle as a new rise -> pedido=0, n_pedidos unchanged.
//  5 Async reset mid-request: pedido=1, assert reset between edges -> pedido, pressionado,
//    n_pedidos=0 immediately; button still held -> pedido=1 again after edge 6 post-release.
//  6 Saturation: 300 press/ack cycles -> n_pedidos=255 and stays; each press still raises pedido.

Source files
------------

// File: rtl/condicionador_botao.sv
// Pedestrian button conditioner: synchronizer, debounce, rising-edge detect, sticky request until ack.
// Optional post-ack lockout (BLOQUEIO state) is built only when BOTAO_LOCKOUT_EN is defined.
module condicionador_botao #(
   parameter int DEB_CYCLES     = 1000,
   parameter int DEB_W          = 10,
   parameter int LOCKOUT_CYCLES = 20000,
   parameter int LCK_W          = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       botao_raw,
   input  logic       ack,
   output logic       pedido,
   output logic       pressionado,
   output logic [7:0] n_pedidos
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      PENDENTE = 2'b01,
      BLOQUEIO = 2'b10
   } estado_t;

   logic             s1;
   logic             s;
   logic             filtrado;
   logic             filtrado_d;
   logic             rise;
   logic             inc;
   logic [DEB_W-1:0] deb_cnt;
   estado_t          estado;
   estado_t          prox;

   // Parameter sanity: counters must be able to reach their terminal values.
   if (DEB_CYCLES < 2 || (DEB_CYCLES - 1) >= (1 << DEB_W)) begin : g_deb_chk
      $error("condicionador_botao: DEB_W too small for DEB_CYCLES");
   end
   if (LOCKOUT_CYCLES < 1 || (LOCKOUT_CYCLES - 1) >= (1 << LCK_W)) begin : g_lck_chk
      $error("condicionador_botao: LCK_W too small for LOCKOUT_CYCLES");
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= botao_raw;
         s  <= s1;
      end
   end

   // A level change is accepted only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filtrado <= 1'b0;
         deb_cnt  <= '0;
      end else if (s == filtrado) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
         filtrado <= s;
         deb_cnt  <= '0;
      end else begin
         deb_cnt <= deb_cnt + DEB_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         filtrado_d <= 1'b0;
      end else begin
         filtrado_d <= filtrado;
      end
   end

   assign rise = filtrado & ~filtrado_d;

`ifdef BOTAO_LOCKOUT_EN
   logic [LCK_W-1:0] lck_cnt;
   logic             lck_fim;

   assign lck_fim = (lck_cnt == LCK_W'(LOCKOUT_CYCLES - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lck_cnt <= '0;
      end else if (estado == BLOQUEIO) begin
         lck_cnt <= lck_fim ? '0 : lck_cnt + LCK_W'(1);
      end else begin
         lck_cnt <= '0;
      end
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= IDLE;
      end else begin
         estado <= prox;
      end
   end

   // Rises outside IDLE are dropped; ack wins over a simultaneous rise in PENDENTE.
   always_comb begin
      prox = estado;
      inc  = 1'b0;
      case (estado)
         IDLE: begin
            if (rise) begin
               prox = PENDENTE;
               inc  = 1'b1;
            end
         end
         PENDENTE: begin
            if (ack) begin
`ifdef BOTAO_LOCKOUT_EN
               prox = BLOQUEIO;
`else
               prox = IDLE;
`endif
            end
         end
`ifdef BOTAO_LOCKOUT_EN
         BLOQUEIO: begin
            if (lck_fim) begin
               prox = IDLE;
            end
         end
`endif
         default: prox = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         n_pedidos <= 8'd0;
      end else if (inc && (n_pedidos != 8'hFF)) begin
         n_pedidos <= n_pedidos + 8'd1;
      end
   end

   assign pedido      = (estado == PENDENTE);
   assign pressionado = filtrado;

endmodule

// File: tb/tb_condicionador_botao.sv
// Randomized and directed bench for condicionador_botao against a sliding-window reference model.
module tb_condicionador_botao;

   localparam int DEB  = 4;
   localparam int LOCK = 8;

   logic       clock;
   logic       reset;
   logic       botao_raw;
   logic       ack;
   logic       pedido;
   logic       pressionado;
   logic [7:0] n_pedidos;

   int n_chk = 0;
   int n_err = 0;

   // Reference model state
   logic hist[$];
   logic m_filt, m_filt_prev, m_ped;
   int   m_cnt, m_lock;

   condicionador_botao #(
      .DEB_CYCLES(DEB), .DEB_W(3), .LOCKOUT_CYCLES(LOCK), .LCK_W(4)
   ) dut (
      .clock(clock), .reset(reset), .botao_raw(botao_raw), .ack(ack),
      .pedido(pedido), .pressionado(pressionado), .n_pedidos(n_pedidos)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic mdl_reset();
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
      m_filt = 1'b0; m_filt_prev = 1'b0; m_ped = 1'b0; m_cnt = 0; m_lock = 0;
   endtask

   // One clock edge of the model. The debounced level flips when the last DEB
   // synchronized samples (raw values two edges old) all disagree with it.
   task automatic mdl_step(input logic r, input logic a);
      logic rise, flip;
      rise = m_filt & ~m_filt_prev;
      if (m_ped) begin
         if (a) begin
            m_ped = 1'b0;
`ifdef BOTAO_LOCKOUT_EN
            m_lock = LOCK;
`endif
         end
      end else if (m_lock > 0) begin
         m_lock--;
      end else if (rise) begin
         m_ped = 1'b1;
         if (m_cnt < 255) m_cnt++;
      end
      flip = 1'b1;
      for (int i = 1; i <= DEB; i++)
         if (hist[hist.size() - 1 - i] == m_filt) flip = 1'b0;
      m_filt_prev = m_filt;
      if (flip) m_filt = ~m_filt;
      hist.push_back(r);
      if (hist.size() > 32) void'(hist.pop_front());
   endtask

   task automatic cyc(input logic r, input logic a);
      botao_raw = r;
      ack       = a;
      @(posedge clock);
      mdl_step(r, a);
      #1;
      chk("pedido", pedido, m_ped);
      chk("pressionado", pressionado, m_filt);
      chk("n_pedidos", n_pedidos, m_cnt);
   endtask

   task automatic hold(input logic r, input int n);
      for (int i = 0; i < n; i++) cyc(r, 1'b0);
   endtask

   // Called at posedge+1: reset must clear outputs immediately, release mid-cycle.
   task automatic do_reset();
      #1 reset = 1'b1;
      #1;
      chk("rst_pedido", pedido, 0);
      chk("rst_pressionado", pressionado, 0);
      chk("rst_n_pedidos", n_pedidos, 0);
      mdl_reset();
      #2 reset = 1'b0;
   endtask

   task automatic press_and_ack(input string tag);
      for (int i = 0; i < 20 && !pedido; i++) cyc(1'b1, 1'b0);
      chk(tag, pedido, 1);
      cyc(1'b1, 1'b1);
      hold(1'b0, 8);
   endtask

   initial begin
      int first_p, first_q, n_before;
      logic r;
      reset = 1'b1; botao_raw = 1'b0; ack = 1'b0;
      mdl_reset();
      #12;
      chk("init_pedido", pedido, 0);
      chk("init_n_pedidos", n_pedidos, 0);
      reset = 1'b0;

      // Clean press latency and hold
      first_p = -1; first_q = -1;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0);
         if (pressionado && first_p < 0) first_p = i;
         if (pedido && first_q < 0) first_q = i;
      end
      chk("lat_pressionado", first_p, 5);
      chk("lat_pedido", first_q, 6);
      hold(1'b1, 50);
      chk("hold_n_pedidos", n_pedidos, 1);
      chk("hold_pedido", pedido, 1);

      // Reset mid-request with button held
      do_reset();
      first_q = -1;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 1'b0);
         if (pedido && first_q < 0) first_q = i;
      end
      chk("rst_relat_pedido", first_q, 6);

      // Ack, then release and re-press
      cyc(1'b1, 1'b1);
      chk("ack_pedido", pedido, 0);
      hold(1'b0, 8);
      hold(1'b1, 8);
      hold(1'b0, 8);

      // Bounce shorter than the filter window
      do_reset();
      for (int i = 0; i < 10; i++) begin
         hold(1'b1, 2);
         hold(1'b0, 2);
      end
      hold(1'b0, 10);
      chk("bounce_pressionado", pressionado, 0);
      chk("bounce_n_pedidos", n_pedidos, 0);

      // Collision: ack on the same edge as a new rise while pending
      hold(1'b1, 10);
      hold(1'b0, 8);
      n_before = n_pedidos;
      for (int i = 0; i < 20; i++) begin
         if (m_filt & ~m_filt_prev) begin
            cyc(1'b1, 1'b1);
            break;
         end
         cyc(1'b1, 1'b0);
      end
      chk("coll_pedido", pedido, 0);
      chk("coll_n_pedidos", n_pedidos, n_before);
      hold(1'b1, 10);
      chk("coll_no_new", pedido, 0);
      hold(1'b0, 8);

      // Randomized segments with sporadic acks
      for (int seg = 0; seg < 300; seg++) begin
         r = 1'($urandom_range(0, 1));
         for (int i = 0; i < int'($urandom_range(1, 10)); i++)
            cyc(r, 1'($urandom_range(0, 7) == 0));
      end
      hold(1'b0, 8);

      // Saturation
      do_reset();
      for (int k = 0; k < 300; k++) press_and_ack("sat_pedido");
      chk("sat_final", n_pedidos, 255);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
